channel: RTL and testbench
==========================

CHANNEL -- requirements
Module: channel

Interface
REQ-001 Parameter WIDTH, default 32: payload width in bits; legal range 1..64.
REQ-002 Parameter HS_PROTOCOL, default P4PhaseBD: handshake protocol on both sides; the alternative is P2PhaseBD.
REQ-003 Port clk, input, 1: single clock; all state updates on the rising edge.
REQ-004 Port rst_n, input, 1: asynchronous active-low reset.
REQ-005 Port s_req, input, 1: sender request; s_data is valid while the request is pending.
REQ-006 Port s_data, input, WIDTH: sender payload (bundled data).
REQ-007 Port s_ack, output, 1: acknowledge to the sender.
REQ-008 Port r_req, output, 1: request to the receiver; r_data is valid while it is pending.
REQ-009 Port r_data, output, WIDTH: receiver payload, driven directly from the slot register.
REQ-010 Port r_ack, input, 1: receiver acknowledge.

Function
REQ-011 The channel SHALL be a one-place buffer: slot register plus full flag.
REQ-012 In P4PhaseBD, the sender side SHALL use an FSM with states S_IDLE and S_ACK.
- S_IDLE, s_req=1 and full=0: capture s_data, set full, set s_ack=1, go to S_ACK.
- S_ACK, s_req=0: set s_ack=0, go to S_IDLE.
REQ-013 In P4PhaseBD, the receiver side SHALL use an FSM with states R_IDLE, R_REQ and R_RTZ.
- R_IDLE, full=1: set r_req=1, go to R_REQ.
- R_REQ, r_ack=1: set r_req=0, clear full, go to R_RTZ.
- R_RTZ, r_ack=0: go to R_IDLE.
REQ-014 Latency SHALL be as follows.
- s_ack rises 1 cycle after s_req is sampled high with the slot empty.
- r_req rises 1 cycle after full is set.
REQ-015 Full/empty boundary: while full=1, a pending s_req SHALL be held unacknowledged; no data is lost and s_data is not sampled.
REQ-016 When full clears and a capture would occur in the same cycle, the capture SHALL be deferred to the next cycle; the full flag has exactly one writer per cycle.
REQ-017 While r_req=1, r_data SHALL remain stable until r_ack is sampled high.
REQ-018 In P2PhaseBD, a sender request is pending when s_req != s_ack; capture SHALL toggle s_ack.
REQ-019 In P2PhaseBD, with full=1 and r_req == r_ack, the channel SHALL toggle r_req. When r_ack toggles to equal r_req, the channel SHALL clear full. The 2-phase receiver SHALL use states R_IDLE and R_REQ only.
REQ-020 Transfers SHALL complete in FIFO order, one item in flight.

Reset
REQ-021 On rst_n=0, immediately and asynchronously, outputs and state SHALL take these values:
- s_ack=0, r_req=0, full=0, r_data=0;
- FSMs in S_IDLE and R_IDLE.
REQ-022 Reset asserted mid-handshake SHALL discard the slot contents. After release, the sender side waits for s_req to match its protocol idle level before the next capture:
- P4PhaseBD: s_req=0;
- P2PhaseBD: s_req == s_ack = 0.

Configuration
REQ-023 Macro CHANNEL_PROBE_EN defined: the module SHALL add the following outputs.
- probe (1 bit): equals full, i.e. data is waiting for the receiver.
- xfer_cnt (32 bits): increments on each receiver-side completion; reset to 0; wraps from 0xFFFFFFFF to 0.
REQ-024 Macro CHANNEL_PROBE_EN undefined: these ports and their logic SHALL be absent, and behaviour is otherwise identical.

Structure
REQ-025 Package channel_pkg SHALL hold the following, shared by the channel and its users:
- the hs_protocol_e enum (P4PhaseBD, P2PhaseBD);
- the sender and receiver FSM state enums.
REQ-026 The receiver-side FSM SHALL be the single sub-module channel_rx_fsm. The sender side and the slot register stay in the top module.

Verification
REQ-027 The bench SHALL cover the following directed scenarios in P4PhaseBD.
- Single transfer: s_req=1, s_data=32'h4100_0201 -> s_ack high at +1 cycle; r_req high at +2; r_data=32'h4100_0201; r_ack completes; probe back to 0; xfer_cnt=1.
- Back-pressure: two sends 32'h0000_0001 then 32'h0000_0002 with r_ack held 0 -> second s_ack stays 0 until the first item is consumed; the receiver gets 1 then 2.
- Reset mid-transfer: rst_n=0 while r_req=1 -> r_req and s_ack drop immediately, full=0, no spurious r_req after release.
- Stability: r_ack delayed 10 cycles -> r_data unchanged for all 10 cycles despite s_data changing.
- Boundary: full clears while s_req=1 -> capture one cycle later, never the same cycle.
REQ-028 The bench SHALL run the same single-transfer scenario in P2PhaseBD with 32'h0000_00FF: s_req toggles 0->1, s_ack toggles to 1, r_req toggles to 1, and r_ack toggles to 1 to complete.

Source files
------------

// File: rtl/channel_pkg.sv
// Shared types for the one-place handshake channel: protocol selector and FSM state enums.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package channel_pkg;

  // Bundled-data handshake flavour used on both sender and receiver sides.
  typedef enum logic {
    P4PhaseBD = 1'b0,
    P2PhaseBD = 1'b1
  } hs_protocol_e;

  // Sender-side states (the 2-phase sender never leaves S_IDLE).
  typedef enum logic {
    S_IDLE = 1'b0,
    S_ACK  = 1'b1
  } tx_state_e;

  // Receiver-side states (R_RTZ is only reachable in the 4-phase protocol).
  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_REQ  = 2'd1,
    R_RTZ  = 2'd2
  } rx_state_e;

endpackage

// File: rtl/channel_rx_fsm.sv
// Receiver-side handshake FSM: offers the slot to the receiver and reports completion.
// Latency: r_req asserts/toggles 1 cycle after full is seen; done pulses in the cycle r_ack completes.
// Backpressure: holds r_req until the receiver acknowledges; never drops an offered item.
// Ports: clk, rst_n (async active-low); full (slot occupied), r_ack (receiver ack) in;
//        r_req (registered request), done (combinational completion pulse, clears full) out.
module channel_rx_fsm
  import channel_pkg::*;
#(
  parameter hs_protocol_e HS_PROTOCOL = P4PhaseBD
) (
  input  logic clk,
  input  logic rst_n,
  input  logic full,
  input  logic r_ack,
  output logic r_req,
  output logic done
);

  rx_state_e state_q, state_d;
  logic      r_req_q, r_req_d;

  always_comb begin
    state_d = state_q;
    r_req_d = r_req_q;
    done    = 1'b0;
    if (HS_PROTOCOL == P4PhaseBD) begin
      case (state_q)
        R_IDLE: if (full) begin
          r_req_d = 1'b1;
          state_d = R_REQ;
        end
        R_REQ: if (r_ack) begin
          r_req_d = 1'b0;
          done    = 1'b1;
          state_d = R_RTZ;
        end
        R_RTZ: if (!r_ack) state_d = R_IDLE;
        default: state_d = R_IDLE;
      endcase
    end else begin
      case (state_q)
        // Offer only once the previous transition has been matched by r_ack.
        R_IDLE: if (full && (r_req_q == r_ack)) begin
          r_req_d = ~r_req_q;
          state_d = R_REQ;
        end
        R_REQ: if (r_ack == r_req_q) begin
          done    = 1'b1;
          state_d = R_IDLE;
        end
        default: state_d = R_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= R_IDLE;
      r_req_q <= 1'b0;
    end else begin
      state_q <= state_d;
      r_req_q <= r_req_d;
    end
  end

  assign r_req = r_req_q;

endmodule

// File: rtl/channel.sv
// One-place bundled-data handshake channel (slot register + full flag) between a sender and a receiver.
// Latency: s_ack 1 cycle after an accepted s_req; r_req 1 cycle after the slot fills.
// Backpressure: while the slot is full, s_req is left unacknowledged and s_data is not sampled.
// Ports: clk, rst_n (async active-low); s_req/s_data in, s_ack out (sender);
//        r_req/r_data out, r_ack in (receiver). HS_PROTOCOL picks 4-phase or 2-phase signalling.
// Optional: define CHANNEL_PROBE_EN to add probe (== full) and a 32-bit wrapping xfer_cnt output.
module channel
  import channel_pkg::*;
#(
  parameter int unsigned  WIDTH       = 32,  // legal range 1..64
  parameter hs_protocol_e HS_PROTOCOL = P4PhaseBD
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             s_req,
  input  logic [WIDTH-1:0] s_data,
  output logic             s_ack,
  output logic             r_req,
  output logic [WIDTH-1:0] r_data,
  input  logic             r_ack
`ifdef CHANNEL_PROBE_EN
  ,
  output logic             probe,
  output logic [31:0]      xfer_cnt
`endif
);

  tx_state_e        tx_state_q, tx_state_d;
  logic             s_ack_q, s_ack_d;
  logic             full_q, full_d;
  logic             armed_q, armed_d;
  logic [WIDTH-1:0] slot_q, slot_d;
  logic             req_pending;
  logic             capture;
  logic             rx_done;

  // A request is pending on a high level in 4-phase, or on s_req != s_ack in 2-phase.
  assign req_pending = (HS_PROTOCOL == P4PhaseBD) ? (s_req && (tx_state_q == S_IDLE))
                                                  : (s_req != s_ack_q);
  // armed_q blocks capture after reset until s_req has returned to its idle level,
  // so a request left over from before reset is not taken as a fresh one.
  assign capture = req_pending && armed_q && !full_q;

  always_comb begin
    tx_state_d = tx_state_q;
    s_ack_d    = s_ack_q;
    slot_d     = slot_q;
    full_d     = full_q;
    armed_d    = armed_q | (s_req == s_ack_q);

    if ((HS_PROTOCOL == P4PhaseBD) && (tx_state_q == S_ACK) && !s_req) begin
      s_ack_d    = 1'b0;
      tx_state_d = S_IDLE;
    end

    // capture needs full_q=0 and rx_done needs full_q=1, so the full flag has one writer per cycle;
    // a request waiting on a full slot is therefore taken the cycle after full clears.
    if (capture) begin
      slot_d = s_data;
      full_d = 1'b1;
      if (HS_PROTOCOL == P4PhaseBD) begin
        s_ack_d    = 1'b1;
        tx_state_d = S_ACK;
      end else begin
        s_ack_d = ~s_ack_q;
      end
    end else if (rx_done) begin
      full_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state_q <= S_IDLE;
      s_ack_q    <= 1'b0;
      full_q     <= 1'b0;
      armed_q    <= 1'b0;
      slot_q     <= '0;
    end else begin
      tx_state_q <= tx_state_d;
      s_ack_q    <= s_ack_d;
      full_q     <= full_d;
      armed_q    <= armed_d;
      slot_q     <= slot_d;
    end
  end

  channel_rx_fsm #(
    .HS_PROTOCOL(HS_PROTOCOL)
  ) u_rx_fsm (
    .clk  (clk),
    .rst_n(rst_n),
    .full (full_q),
    .r_ack(r_ack),
    .r_req(r_req),
    .done (rx_done)
  );

  assign s_ack  = s_ack_q;
  assign r_data = slot_q;

`ifdef CHANNEL_PROBE_EN
  logic [31:0] xfer_cnt_q, xfer_cnt_d;

  always_comb begin
    xfer_cnt_d = xfer_cnt_q + 32'(rx_done);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) xfer_cnt_q <= '0;
    else        xfer_cnt_q <= xfer_cnt_d;
  end

  assign probe    = full_q;
  assign xfer_cnt = xfer_cnt_q;
`endif

endmodule

// File: tb/tb_channel.sv
module tb_channel;
  import channel_pkg::*;

  logic        clk, rst_n;
  logic        s_req4, s_ack4, r_req4, r_ack4;
  logic [31:0] s_data4, r_data4;
  logic        s_req2, s_ack2, r_req2, r_ack2;
  logic [31:0] s_data2, r_data2;
`ifdef CHANNEL_PROBE_EN
  logic        probe4, probe2;
  logic [31:0] xfer4, xfer2;
`endif

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model: the channel is an order-preserving one-place buffer, so every accepted
  // payload must appear at the receiver in acceptance order.
  logic [31:0] exp4_q[$];
  logic [31:0] exp2_q[$];
  logic [31:0] m4_exp = '0, m2_exp = '0;
  logic        m4_prev = 1'b0, m2_prev = 1'b0;

  channel #(.WIDTH(32), .HS_PROTOCOL(P4PhaseBD)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .s_req(s_req4), .s_data(s_data4), .s_ack(s_ack4),
    .r_req(r_req4), .r_data(r_data4), .r_ack(r_ack4)
`ifdef CHANNEL_PROBE_EN
    , .probe(probe4), .xfer_cnt(xfer4)
`endif
  );

  channel #(.WIDTH(32), .HS_PROTOCOL(P2PhaseBD)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .s_req(s_req2), .s_data(s_data2), .s_ack(s_ack2),
    .r_req(r_req2), .r_data(r_data2), .r_ack(r_ack2)
`ifdef CHANNEL_PROBE_EN
    , .probe(probe2), .xfer_cnt(xfer2)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  // Monitor, 4-phase: each rising r_req delivers the oldest accepted payload, which must then hold.
  always @(negedge clk) begin
    if (!rst_n) m4_prev = 1'b0;
    else begin
      if (r_req4 && !m4_prev) begin
        if (exp4_q.size() == 0) chk("r4_spurious_req", 64'(r_req4), 64'd0);
        else begin
          m4_exp = exp4_q.pop_front();
          chk("r4_data", 64'(r_data4), 64'(m4_exp));
        end
      end else if (r_req4) chk("r4_stable", 64'(r_data4), 64'(m4_exp));
      m4_prev = r_req4;
    end
  end

  // Monitor, 2-phase: each r_req transition delivers the oldest accepted payload.
  always @(negedge clk) begin
    if (!rst_n) m2_prev = 1'b0;
    else begin
      if (r_req2 != m2_prev) begin
        if (exp2_q.size() == 0) chk("r2_spurious_toggle", 64'(r_req2), 64'(m2_prev));
        else begin
          m2_exp = exp2_q.pop_front();
          chk("r2_data", 64'(r_data2), 64'(m2_exp));
        end
      end else if (r_req2 != r_ack2) chk("r2_stable", 64'(r_data2), 64'(m2_exp));
      m2_prev = r_req2;
    end
  end

  // Wait for the 4-phase ack of an already-raised request, record the payload, finish the handshake.
  task automatic wait_ack4_push(input logic [31:0] d);
    for (int i = 0; i < 200; i++) begin @(negedge clk); if (s_ack4) break; end
    chk("s4_ack", 64'(s_ack4), 64'd1);
    if (s_ack4) exp4_q.push_back(d);
    s_req4 = 1'b0;
    for (int i = 0; i < 200; i++) begin @(negedge clk); if (!s_ack4) break; end
    chk("s4_ack_rtz", 64'(s_ack4), 64'd0);
  endtask

  task automatic send4(input logic [31:0] d);
    s_data4 = d;
    s_req4  = 1'b1;
    wait_ack4_push(d);
  endtask

  task automatic recv4(input int hold);
    for (int i = 0; i < 200; i++) begin if (r_req4) break; @(negedge clk); end
    chk("r4_req", 64'(r_req4), 64'd1);
    repeat (hold) @(negedge clk);
    r_ack4 = 1'b1;
    for (int i = 0; i < 200; i++) begin @(negedge clk); if (!r_req4) break; end
    chk("r4_req_drop", 64'(r_req4), 64'd0);
    r_ack4 = 1'b0;
  endtask

  task automatic send2(input logic [31:0] d);
    s_data2 = d;
    s_req2  = ~s_req2;
    for (int i = 0; i < 200; i++) begin @(negedge clk); if (s_ack2 == s_req2) break; end
    chk("s2_ack_toggle", 64'(s_ack2), 64'(s_req2));
    if (s_ack2 == s_req2) exp2_q.push_back(d);
  endtask

  task automatic recv2(input int hold);
    for (int i = 0; i < 200; i++) begin if (r_req2 != r_ack2) break; @(negedge clk); end
    chk("r2_req_toggle", 64'(r_req2 != r_ack2), 64'd1);
    repeat (hold) @(negedge clk);
    r_ack2 = r_req2;
    @(negedge clk);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b1;
    s_req4 = 1'b0; s_data4 = '0; r_ack4 = 1'b0;
    s_req2 = 1'b0; s_data2 = '0; r_ack2 = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst4_s_ack", 64'(s_ack4), 64'd0);
    chk("rst4_r_req", 64'(r_req4), 64'd0);
    chk("rst4_r_data", 64'(r_data4), 64'd0);
    chk("rst2_s_ack", 64'(s_ack2), 64'd0);
    chk("rst2_r_req", 64'(r_req2), 64'd0);
    chk("rst2_r_data", 64'(r_data2), 64'd0);
`ifdef CHANNEL_PROBE_EN
    chk("rst4_probe", 64'(probe4), 64'd0);
    chk("rst4_xfer", 64'(xfer4), 64'd0);
`endif
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single transfer: s_ack at +1, r_req at +2.
    s_data4 = 32'h4100_0201;
    s_req4  = 1'b1;
    @(negedge clk);
    chk("single_s_ack_lat1", 64'(s_ack4), 64'd1);
    chk("single_r_req_not_yet", 64'(r_req4), 64'd0);
    if (s_ack4) exp4_q.push_back(32'h4100_0201);
    s_req4 = 1'b0;
    @(negedge clk);
    chk("single_r_req_lat2", 64'(r_req4), 64'd1);
    chk("single_r_data", 64'(r_data4), 64'h4100_0201);
    chk("single_s_ack_rtz", 64'(s_ack4), 64'd0);
`ifdef CHANNEL_PROBE_EN
    chk("single_probe_full", 64'(probe4), 64'd1);
`endif
    recv4(0);
    @(negedge clk);
`ifdef CHANNEL_PROBE_EN
    chk("single_probe_empty", 64'(probe4), 64'd0);
    chk("single_xfer_cnt", 64'(xfer4), 64'd1);
`endif

    // Back-pressure: second item waits while the first is unconsumed.
    send4(32'h0000_0001);
    s_data4 = 32'h0000_0002;
    s_req4  = 1'b1;
    repeat (6) begin
      @(negedge clk);
      chk("bp_second_ack_held", 64'(s_ack4), 64'd0);
    end
    fork
      recv4(0);
      wait_ack4_push(32'h0000_0002);
    join
    recv4(0);

    // Stability: receiver stalls 10 cycles while the sender's data bus churns.
    send4(32'hCAFE_0001);
    fork
      recv4(10);
      begin
        repeat (12) begin s_data4 = $urandom; @(negedge clk); end
      end
    join

    // Boundary: full clears while s_req waits -> capture the following cycle, not the same one.
    send4(32'hA5A5_0001);
    for (int i = 0; i < 20; i++) begin if (r_req4) break; @(negedge clk); end
    s_data4 = 32'hA5A5_0002;
    s_req4  = 1'b1;
    @(negedge clk);
    r_ack4 = 1'b1;
    @(negedge clk);
    chk("bnd_full_cleared", 64'(r_req4), 64'd0);
    chk("bnd_no_same_cycle_capture", 64'(s_ack4), 64'd0);
    r_ack4 = 1'b0;
    @(negedge clk);
    chk("bnd_capture_next_cycle", 64'(s_ack4), 64'd1);
    if (s_ack4) exp4_q.push_back(32'hA5A5_0002);
    s_req4 = 1'b0;
    recv4(0);
    repeat (3) @(negedge clk);

    // Reset mid-transfer with s_ack and r_req both high.
    s_data4 = 32'hDEAD_BEEF;
    s_req4  = 1'b1;
    for (int i = 0; i < 20; i++) begin @(negedge clk); if (s_ack4) break; end
    if (s_ack4) exp4_q.push_back(32'hDEAD_BEEF);
    @(negedge clk);
    chk("rmid_pre_r_req", 64'(r_req4), 64'd1);
    chk("rmid_pre_s_ack", 64'(s_ack4), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rmid_r_req_async", 64'(r_req4), 64'd0);
    chk("rmid_s_ack_async", 64'(s_ack4), 64'd0);
    chk("rmid_r_data_clear", 64'(r_data4), 64'd0);
`ifdef CHANNEL_PROBE_EN
    chk("rmid_probe_clear", 64'(probe4), 64'd0);
`endif
    exp4_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("rmid_stale_req_ignored", 64'(s_ack4), 64'd0);
    end
    s_req4 = 1'b0;
    repeat (4) begin
      @(negedge clk);
      chk("rmid_no_spurious_r_req", 64'(r_req4), 64'd0);
    end

    // Randomised 4-phase traffic.
    fork
      begin for (int k = 0; k < 30; k++) send4($urandom); end
      begin for (int j = 0; j < 30; j++) recv4(int'($urandom_range(0, 3))); end
    join
    repeat (3) @(negedge clk);
    chk("p4_all_delivered", 64'(exp4_q.size()), 64'd0);

    // 2-phase single transfer.
    s_data2 = 32'h0000_00FF;
    s_req2  = 1'b1;
    @(negedge clk);
    chk("p2_s_ack_toggle", 64'(s_ack2), 64'd1);
    chk("p2_r_req_not_yet", 64'(r_req2), 64'd0);
    if (s_ack2) exp2_q.push_back(32'h0000_00FF);
    @(negedge clk);
    chk("p2_r_req_toggle", 64'(r_req2), 64'd1);
    chk("p2_r_data", 64'(r_data2), 64'h0000_00FF);
`ifdef CHANNEL_PROBE_EN
    chk("p2_probe_full", 64'(probe2), 64'd1);
`endif
    r_ack2 = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("p2_r_req_no_retoggle", 64'(r_req2), 64'd1);
`ifdef CHANNEL_PROBE_EN
    chk("p2_probe_empty", 64'(probe2), 64'd0);
    chk("p2_xfer_cnt", 64'(xfer2), 64'd1);
`endif

    // Randomised 2-phase traffic.
    fork
      begin for (int k = 0; k < 20; k++) send2($urandom); end
      begin for (int j = 0; j < 20; j++) recv2(int'($urandom_range(0, 3))); end
    join
    repeat (3) @(negedge clk);
    chk("p2_all_delivered", 64'(exp2_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
